// File: rtl/puf_crp_sequencer.sv
// Query sequencer for one arbiter-PUF: challenge -> reset pulse -> gap -> enable/race -> capture.
// Optional PUF_MAJORITY_VOTE_EN: three evaluation rounds per query, bitwise majority response.
module puf_crp_sequencer #(
    parameter int C_BITS       = 4,
    parameter int R_BITS       = 32,
    parameter int SETUP_CYCLES = 1,
    parameter int RESET_CYCLES = 1,
    parameter int EVAL_CYCLES  = 16 * C_BITS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ch_valid,
    output logic              ch_ready,
    input  logic [C_BITS-1:0] ch_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [R_BITS-1:0] rsp_data,
    output logic              busy,
    output logic              puf_reset,
    output logic              puf_enable,
    output logic [C_BITS-1:0] puf_challenge,
    input  logic [R_BITS-1:0] puf_resp
);
    localparam int MAX_SR  = (SETUP_CYCLES > RESET_CYCLES) ? SETUP_CYCLES : RESET_CYCLES;
    localparam int MAX_CYC = (MAX_SR > EVAL_CYCLES) ? MAX_SR : EVAL_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES);
    localparam logic [CNT_W-1:0] RESET_LD = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] EVAL_LD  = CNT_W'(EVAL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_RST, S_GAP, S_EVAL, S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [C_BITS-1:0] chal_q, chal_d;
    logic [R_BITS-1:0] rsp_q, rsp_d;
    logic              ch_ready_q, rsp_valid_q, busy_q, puf_reset_q, puf_enable_q;
    logic              accept, last;

`ifdef PUF_MAJORITY_VOTE_EN
    logic [1:0]        round_q, round_d;
    logic [R_BITS-1:0] samp0_q, samp0_d, samp1_q, samp1_d;
    logic [R_BITS-1:0] vote;

    // Third round's sample is voted straight from puf_resp on the capture edge.
    genvar gi;
    generate
        for (gi = 0; gi < R_BITS; gi++) begin : g_vote
            assign vote[gi] = (samp0_q[gi] & samp1_q[gi]) | (samp0_q[gi] & puf_resp[gi])
                            | (samp1_q[gi] & puf_resp[gi]);
        end
    endgenerate
`endif

    assign accept = ch_valid && ch_ready_q;
    assign last   = (cnt_q == CNT_ONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chal_d  = chal_q;
        rsp_d   = rsp_q;
`ifdef PUF_MAJORITY_VOTE_EN
        round_d = round_q;
        samp0_d = samp0_q;
        samp1_d = samp1_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                    chal_d  = ch_data;
                end
            end
            S_SETUP: begin
                if (last) begin
                    state_d = S_RST;
                    cnt_d   = RESET_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_RST: begin
                if (last) begin
                    state_d = S_GAP;
                    cnt_d   = SETUP_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_GAP: begin
                if (last) begin
                    state_d = S_EVAL;
                    cnt_d   = EVAL_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_EVAL: begin
                if (last) begin
`ifdef PUF_MAJORITY_VOTE_EN
                    if (round_q == 2'd2) begin
                        state_d = S_OUT;
                        cnt_d   = '0;
                        rsp_d   = vote;
                        round_d = 2'd0;
                    end else begin
                        state_d = S_RST;
                        cnt_d   = RESET_LD;
                        round_d = round_q + 2'd1;
                        if (round_q == 2'd0) begin
                            samp0_d = puf_resp;
                        end else begin
                            samp1_d = puf_resp;
                        end
                    end
`else
                    state_d = S_OUT;
                    cnt_d   = '0;
                    rsp_d   = puf_resp;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_OUT: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshake and PUF controls are decoded from the next state so they leave a flop directly.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            chal_q       <= '0;
            rsp_q        <= '0;
            ch_ready_q   <= 1'b1;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            puf_reset_q  <= 1'b0;
            puf_enable_q <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
            round_q      <= 2'd0;
            samp0_q      <= '0;
            samp1_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            chal_q       <= chal_d;
            rsp_q        <= rsp_d;
            ch_ready_q   <= (state_d == S_IDLE);
            rsp_valid_q  <= (state_d == S_OUT);
            busy_q       <= (state_d != S_IDLE);
            puf_reset_q  <= (state_d == S_RST);
            puf_enable_q <= (state_d == S_EVAL);
`ifdef PUF_MAJORITY_VOTE_EN
            round_q      <= round_d;
            samp0_q      <= samp0_d;
            samp1_q      <= samp1_d;
`endif
        end
    end

    assign ch_ready      = ch_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_q;
    assign busy          = busy_q;
    assign puf_reset     = puf_reset_q;
    assign puf_enable    = puf_enable_q;
    assign puf_challenge = chal_q;

endmodule

// File: doc/puf_crp_sequencer.md
Name: puf_crp_sequencer

Overview:
Synthesizable initiator that drives one arbiter-PUF instance through its query protocol. The protocol is: apply challenge, pulse reset, release, enable, wait the worst-case race time, then sample the response. It accepts challenges over a valid/ready handshake and returns captured responses over a second valid/ready handshake. It sits between the PUF instance and the on-chip enrolment/authentication logic, replacing bench-driven sequencing.

Parameters:
C_BITS, 4, challenge width; also the number of PUF delay stages.
R_BITS, 32, response width.
SETUP_CYCLES, 1, cycles the challenge is held before the reset pulse; also the low gap between reset release and enable. Must be >=1.
RESET_CYCLES, 1, width of the puf_reset pulse in cycles. Must be >=1.
EVAL_CYCLES, 64, cycles puf_enable is held high before sampling. Default is 16*C_BITS. Must be >=1.

Ports:
clk  in  1  system clock; all logic rising-edge.
reset  in  1  synchronous, active-high reset.
ch_valid  in  1  challenge offered.
ch_ready  out  1  sequencer can accept a challenge.
ch_data  in  C_BITS  challenge value.
rsp_valid  out  1  response available.
rsp_ready  in  1  consumer takes response.
rsp_data  out  R_BITS  captured response.
busy  out  1  query in progress (any state except IDLE).
puf_reset  out  1  to PUF reset.
puf_enable  out  1  to PUF enable.
puf_challenge  out  C_BITS  to PUF challenge.
puf_resp  in  R_BITS  from PUF response.

Behaviour:
- Reset state: IDLE. All outputs 0 except ch_ready=1. rsp_data=0, puf_challenge=0, internal counter=0.
- Reset asserted mid-query aborts the query: state goes to IDLE, puf_enable and puf_reset go to 0 the next cycle, and any pending response is discarded.
- FSM states and exits:
  - IDLE: exits on accept.
  - SETUP: SETUP_CYCLES cycles, then RST.
  - RST: RESET_CYCLES cycles, then GAP.
  - GAP: SETUP_CYCLES cycles, then EVAL.
  - EVAL: EVAL_CYCLES cycles, then OUT.
  - OUT: exits on response transfer.
- Accept: ch_valid && ch_ready at an edge. ch_ready=1 only in IDLE. On accept, ch_data is registered into puf_challenge.
- puf_challenge holds stable from accept until the next accept; it does not change while busy.
- Output levels by state:
  - puf_reset=1 only in RST.
  - puf_enable=1 only in EVAL.
  - puf_reset and puf_enable are never high together.
  - Both are registered outputs (no glitches).
- Capture: on the final EVAL cycle edge, puf_resp is registered into rsp_data.
- OUT: rsp_valid=1 and rsp_data is held stable until rsp_ready is sampled high. The transfer edge returns the FSM to IDLE. rsp_data keeps its last value afterwards.
- Latency: rsp_valid rises exactly L edges after the accepting edge, where L = SETUP_CYCLES+RESET_CYCLES+SETUP_CYCLES+EVAL_CYCLES (67 at defaults).
- rsp_ready held high in OUT gives a 1-cycle OUT. Back-to-back throughput is one query per L+2 cycles, since IDLE takes a cycle before the next accept.
- ch_valid high while busy is ignored (no accept). ch_data changes while busy have no effect.
- Phase counter: one down-counter, width $clog2 of max(SETUP_CYCLES,RESET_CYCLES,EVAL_CYCLES)+1. It is loaded on each state entry, and the state changes when it reaches 1.

Optional Feature:
Macro PUF_MAJORITY_VOTE_EN.
- Defined:
  - Each query performs 3 evaluation rounds (RST, GAP, EVAL) after a single SETUP, with the same challenge.
  - puf_resp is sampled at the end of each EVAL into three R_BITS registers.
  - rsp_data is the bitwise majority of the three samples, registered on entry to OUT.
  - Latency L = SETUP_CYCLES + 3*(RESET_CYCLES+SETUP_CYCLES+EVAL_CYCLES), which is 199 at defaults.
  - A 2-bit round counter tracks rounds and is cleared by reset.
- Undefined: a single round; no vote registers are synthesized.

Test Plan:
1. Reset, then apply ch_data=4'b1010 with ch_valid=1 and a PUF model returning 32'hDEADBEEF -> expect:
   - puf_challenge=1010 one edge after accept.
   - puf_reset high for exactly 1 cycle; puf_enable high for exactly 64 cycles.
   - rsp_valid at edge +67 with rsp_data=32'hDEADBEEF.
2. Backpressure: rsp_ready=0 for 10 cycles in OUT while puf_resp changes to 32'h0 -> rsp_valid and rsp_data=32'hDEADBEEF stay stable; ch_ready stays 0.
3. Sweep all 16 challenges with rsp_ready=1 and a model where response = {8{challenge}} -> each rsp_data matches; accepts are spaced exactly 69 cycles apart.
4. ch_valid high throughout a query with ch_data toggling -> exactly one accept per query; puf_challenge is constant while busy.
5. Assert reset at EVAL cycle 20 -> next cycle state is IDLE: puf_enable=0, busy=0, ch_ready=1, rsp_valid=0, and no response is emitted.
6. PUF_MAJORITY_VOTE_EN defined, model returns 32'hFF00FF00, 32'hF0F0F0F0, 32'hFF00FF00 across the three rounds -> rsp_data=32'hFF00FF00 at edge +199, with three puf_reset pulses.
